// File: rtl/poker_pkg.sv
// -----------------------------------------------------------------------------
// poker_pkg
// Shared types and constants for the poker table blocks.
//   arb_state_t    : states of the rank evaluator arbiter FSM
//   RANK_W_DEFAULT : width of a hand rank produced by the evaluator
// -----------------------------------------------------------------------------
package poker_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_DONE,
    RESPOND
  } arb_state_t;

  localparam int RANK_W_DEFAULT = 9;

endpackage

// File: rtl/rank_eval_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Chooses the first set bit of pending,
// scanning upward from (last_grant + 1) mod NUM_PLAYERS with wrap-around.
//   pending     in  : latched request bits, one per player
//   last_grant  in  : index of the most recently granted player
//   grant       out : chosen player index (0 when nothing is pending)
//   grant_valid out : at least one request is pending
// -----------------------------------------------------------------------------
module rr_pick
  import poker_pkg::*;
#(
  parameter int NUM_PLAYERS = 4,
  localparam int SEL_W = $clog2(NUM_PLAYERS)
) (
  input  logic [NUM_PLAYERS-1:0] pending,
  input  logic [SEL_W-1:0]       last_grant,
  output logic [SEL_W-1:0]       grant,
  output logic                   grant_valid
);

  int w_best_dist;

  // Every pending player gets a distance from the slot after last_grant;
  // the smallest distance is next in line. Distances are unique, so the
  // strict less-than gives exactly one winner.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    w_best_dist = NUM_PLAYERS;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (pending[i]) begin
        if (((i + NUM_PLAYERS - int'(last_grant) - 1) % NUM_PLAYERS) < w_best_dist) begin
          w_best_dist = (i + NUM_PLAYERS - int'(last_grant) - 1) % NUM_PLAYERS;
          grant       = SEL_W'(i);
          grant_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rank_eval_arbiter.sv
// -----------------------------------------------------------------------------
// rank_eval_arbiter
// Shares one hand rank evaluator between NUM_PLAYERS player FSMs. Requests
// are latched into a pending vector and granted round-robin; the granted
// player's hand index drives the evaluator, and the result comes back to that
// player with a one-hot done pulse. A grant with no answer within
// TIMEOUT_CYCLES is aborted with rank 0 and a timeout_err pulse.
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   req          : per-player evaluation request pulses
//   eval_start   : one-cycle start pulse to the evaluator
//   eval_sel     : hand memory index, stable from START through RESPOND
//   eval_done    : evaluator completion pulse, eval_rank valid with it
//   player_done  : one-hot one-cycle completion pulse to the served player
//   rank_out     : result for the player in player_done, held until next
//   timeout_err  : one-cycle pulse when a grant is aborted by timeout
//   busy         : FSM is not IDLE
//   pending      : latched, not-yet-granted requests
// -----------------------------------------------------------------------------
module rank_eval_arbiter
  import poker_pkg::*;
#(
  parameter int NUM_PLAYERS    = 4,
  parameter int RANK_W         = RANK_W_DEFAULT,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PLAYERS-1:0]         req,
  output logic                           eval_start,
  output logic [$clog2(NUM_PLAYERS)-1:0] eval_sel,
  input  logic                           eval_done,
  input  logic [RANK_W-1:0]              eval_rank,
  output logic [NUM_PLAYERS-1:0]         player_done,
  output logic [RANK_W-1:0]              rank_out,
  output logic                           timeout_err,
  output logic                           busy,
  output logic [NUM_PLAYERS-1:0]         pending
);

  localparam int SEL_W = $clog2(NUM_PLAYERS);
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_FIRST = SEL_W'(NUM_PLAYERS - 1);

  arb_state_t             r_state;
  logic [NUM_PLAYERS-1:0] r_pending;
  logic [SEL_W-1:0]       r_last_grant;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_eval_start;
  logic [SEL_W-1:0]       r_eval_sel;
  logic [NUM_PLAYERS-1:0] r_player_done;
  logic [RANK_W-1:0]      r_rank_out;
  logic                   r_timeout_err;

  logic [SEL_W-1:0]       w_grant;
  logic                   w_grant_valid;
  logic [NUM_PLAYERS-1:0] w_grant_mask;
  logic [NUM_PLAYERS-1:0] w_sel_mask;
  logic [NUM_PLAYERS-1:0] w_clr_mask;

  rr_pick #(
    .NUM_PLAYERS (NUM_PLAYERS)
  ) u_rr_pick (
    .pending     (r_pending),
    .last_grant  (r_last_grant),
    .grant       (w_grant),
    .grant_valid (w_grant_valid)
  );

  assign w_grant_mask = NUM_PLAYERS'(1) << w_grant;
  assign w_sel_mask   = NUM_PLAYERS'(1) << r_eval_sel;

  // Only the IDLE->START edge consumes a pending bit; a new req from the
  // player in service (even alongside its eval_done) stays latched.
  assign w_clr_mask = (r_state == IDLE && w_grant_valid) ? w_grant_mask : '0;

  // Request latch and the arbitration FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_pending     <= '0;
      r_last_grant  <= SEL_FIRST;
      r_cnt         <= '0;
      r_eval_start  <= 1'b0;
      r_eval_sel    <= '0;
      r_player_done <= '0;
      r_rank_out    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_pending <= (r_pending | req) & ~w_clr_mask;
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_state      <= START;
            r_eval_sel   <= w_grant;
            r_last_grant <= w_grant;
            r_eval_start <= 1'b1;
          end
        end
        START: begin
          r_state      <= WAIT_DONE;
          r_eval_start <= 1'b0;
          r_cnt        <= '0;
        end
        WAIT_DONE: begin
          // A real answer on the timeout cycle takes precedence over abort.
          if (eval_done) begin
            r_state       <= RESPOND;
            r_rank_out    <= eval_rank;
            r_player_done <= w_sel_mask;
          end else if (r_cnt == CNT_LAST) begin
            r_state       <= RESPOND;
            r_rank_out    <= '0;
            r_player_done <= w_sel_mask;
            r_timeout_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESPOND: begin
          r_state       <= IDLE;
          r_player_done <= '0;
          r_timeout_err <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign eval_start  = r_eval_start;
  assign eval_sel    = r_eval_sel;
  assign player_done = r_player_done;
  assign rank_out    = r_rank_out;
  assign timeout_err = r_timeout_err;
  assign busy        = (r_state != IDLE);
  assign pending     = r_pending;

endmodule

// File: tb/tb_rank_eval_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rank_eval_arbiter
// Self-checking bench for rank_eval_arbiter (4 players, 9-bit rank, 64-cycle
// timeout). A small evaluator model answers eval_start after a programmable
// delay; expected grants and responses are queued when requests are driven
// and popped when the DUT raises eval_start / player_done.
// -----------------------------------------------------------------------------
module tb_rank_eval_arbiter;

  localparam int N  = 4;
  localparam int RW = 9;
  localparam int TO = 64;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic          eval_start;
  logic [1:0]    eval_sel;
  logic          eval_done;
  logic [RW-1:0] eval_rank;
  logic [N-1:0]  player_done;
  logic [RW-1:0] rank_out;
  logic          timeout_err;
  logic          busy;
  logic [N-1:0]  pending;

  typedef struct {
    int            player;
    logic [RW-1:0] rank;
    logic          tmo;
  } exp_t;

  typedef struct {
    logic [N-1:0]  reqMask;
    int            delay;
    logic [RW-1:0] rank;
    int            expSel;
  } vec_t;

  exp_t          sbQ[$];
  int            expGrantQ[$];
  vec_t          vecs[4];
  int            testsRun;
  int            failCount;
  int            cycle;
  int            lastStartCycle;
  int            doneCycle;
  int            autoDelay;
  int            evalCountdown;
  logic [RW-1:0] autoRank;

  rank_eval_arbiter #(
    .NUM_PLAYERS    (N),
    .RANK_W         (RW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .eval_start  (eval_start),
    .eval_sel    (eval_sel),
    .eval_done   (eval_done),
    .eval_rank   (eval_rank),
    .player_done (player_done),
    .rank_out    (rank_out),
    .timeout_err (timeout_err),
    .busy        (busy),
    .pending     (pending)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something upstream never returns
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] r);
    req = r;
  endtask

  // One clock: advance past the edge, score any grant/response, then let the
  // evaluator model drive eval_done/eval_rank for the coming cycle.
  task automatic stepCycle();
    exp_t e;
    int   g;
    @(posedge clk);
    #1;
    cycle++;
    req       = '0;
    eval_done = 1'b0;
    eval_rank = 9'h1FF;
    if (eval_start) begin
      lastStartCycle = cycle;
      if (expGrantQ.size() == 0) begin
        checkOutput("unexpected_start", 32'(eval_start), 32'd0);
      end else begin
        g = expGrantQ.pop_front();
        checkOutput("grant_sel", 32'(eval_sel), 32'(g));
      end
    end
    if (player_done != '0 || timeout_err) begin
      doneCycle = cycle;
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_done", 32'({player_done, timeout_err}), 32'd0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("player_done", 32'(player_done), 32'(1) << e.player);
        checkOutput("rank_out", 32'(rank_out), 32'(e.rank));
        checkOutput("timeout_err", 32'(timeout_err), 32'(e.tmo));
      end
    end
    if (evalCountdown > 0) begin
      evalCountdown--;
      if (evalCountdown == 0) begin
        eval_done = 1'b1;
        eval_rank = autoRank;
      end
    end
    if (eval_start && autoDelay > 0) evalCountdown = autoDelay;
  endtask

  task automatic waitStart(input int budget);
    int i;
    i = 0;
    do begin
      stepCycle();
      i++;
    end while (!eval_start && i < budget);
    checkOutput("start_seen", 32'(eval_start), 32'd1);
  endtask

  task automatic waitIdle(input int budget);
    int i;
    i = 0;
    do begin
      stepCycle();
      i++;
    end while ((busy || pending != '0 || sbQ.size() != 0 || expGrantQ.size() != 0) && i < budget);
    checkOutput("drain", 32'(busy) + 32'(pending) + 32'(sbQ.size()) + 32'(expGrantQ.size()), 32'd0);
  endtask

  initial begin
    testsRun       = 0;
    failCount      = 0;
    cycle          = 0;
    lastStartCycle = 0;
    doneCycle      = 0;
    autoDelay      = 0;
    evalCountdown  = 0;
    autoRank       = '0;
    rst_n          = 1'b0;
    req            = '0;
    eval_done      = 1'b0;
    eval_rank      = '0;

    vecs[0] = '{reqMask: 4'b0100, delay: 5, rank: 9'h1A3, expSel: 2};
    vecs[1] = '{reqMask: 4'b0001, delay: 1, rank: 9'h001, expSel: 0};
    vecs[2] = '{reqMask: 4'b0010, delay: 4, rank: 9'h100, expSel: 1};
    vecs[3] = '{reqMask: 4'b1000, delay: 2, rank: 9'h0FF, expSel: 3};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_eval_start", 32'(eval_start), 32'd0);
    checkOutput("rst_eval_sel", 32'(eval_sel), 32'd0);
    checkOutput("rst_player_done", 32'(player_done), 32'd0);
    checkOutput("rst_rank_out", 32'(rank_out), 32'd0);
    checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_pending", 32'(pending), 32'd0);
    rst_n = 1'b1;
    stepCycle();

    // Single requests from a table, one at a time
    for (int v = 0; v < 4; v++) begin
      autoDelay = vecs[v].delay;
      autoRank  = vecs[v].rank;
      expGrantQ.push_back(vecs[v].expSel);
      sbQ.push_back('{player: vecs[v].expSel, rank: vecs[v].rank, tmo: 1'b0});
      applyStimulus(vecs[v].reqMask);
      stepCycle();
      checkOutput("pend_latched", 32'(pending), 32'(vecs[v].reqMask));
      checkOutput("no_early_start", 32'(eval_start), 32'd0);
      stepCycle();
      checkOutput("start_latency", 32'(eval_start), 32'd1);
      checkOutput("busy_on", 32'(busy), 32'd1);
      waitIdle(40);
      checkOutput("done_latency", 32'(doneCycle - lastStartCycle), 32'(vecs[v].delay + 1));
      checkOutput("busy_drop", 32'(cycle - doneCycle), 32'd1);
      checkOutput("rank_hold", 32'(rank_out), 32'(vecs[v].rank));
    end

    // Contention: 1011 after player 3 was last -> 0, 1, 3
    autoDelay = 3;
    autoRank  = 9'h0AA;
    expGrantQ.push_back(0);
    expGrantQ.push_back(1);
    expGrantQ.push_back(3);
    sbQ.push_back('{player: 0, rank: 9'h0AA, tmo: 1'b0});
    sbQ.push_back('{player: 1, rank: 9'h0AA, tmo: 1'b0});
    sbQ.push_back('{player: 3, rank: 9'h0AA, tmo: 1'b0});
    applyStimulus(4'b1011);
    stepCycle();
    checkOutput("cont_pend0", 32'(pending), 32'b1011);
    waitStart(20);
    checkOutput("cont_pend1", 32'(pending), 32'b1010);
    waitStart(20);
    checkOutput("cont_pend2", 32'(pending), 32'b1000);
    waitStart(20);
    checkOutput("cont_pend3", 32'(pending), 32'b0000);
    waitIdle(40);

    // Round-robin wrap: last grant was 3, so 1001 serves 0 then 3
    autoRank = 9'h123;
    expGrantQ.push_back(0);
    expGrantQ.push_back(3);
    sbQ.push_back('{player: 0, rank: 9'h123, tmo: 1'b0});
    sbQ.push_back('{player: 3, rank: 9'h123, tmo: 1'b0});
    applyStimulus(4'b1001);
    waitStart(20);
    checkOutput("wrap_pend", 32'(pending), 32'b1000);
    waitIdle(40);

    // Timeout: evaluator never answers player 1
    autoDelay = 0;
    expGrantQ.push_back(1);
    sbQ.push_back('{player: 1, rank: 9'h000, tmo: 1'b1});
    applyStimulus(4'b0010);
    waitIdle(TO + 40);
    checkOutput("timeout_latency", 32'(doneCycle - lastStartCycle), 32'(TO + 1));
    eval_done = 1'b1;
    eval_rank = 9'h077;
    stepCycle();
    checkOutput("idle_done_pd", 32'(player_done), 32'd0);
    checkOutput("idle_done_busy", 32'(busy), 32'd0);
    stepCycle();
    checkOutput("idle_done_pd2", 32'(player_done), 32'd0);
    checkOutput("idle_done_rank", 32'(rank_out), 32'd0);
    checkOutput("idle_done_terr", 32'(timeout_err), 32'd0);

    // eval_done lands exactly on the timeout cycle: done wins
    autoDelay = TO;
    autoRank  = 9'h0F5;
    expGrantQ.push_back(1);
    sbQ.push_back('{player: 1, rank: 9'h0F5, tmo: 1'b0});
    applyStimulus(4'b0010);
    waitIdle(TO + 40);
    checkOutput("race_latency", 32'(doneCycle - lastStartCycle), 32'(TO + 1));

    // Player 2 re-requests in the same cycle as its eval_done
    autoDelay = 0;
    expGrantQ.push_back(2);
    expGrantQ.push_back(2);
    sbQ.push_back('{player: 2, rank: 9'h055, tmo: 1'b0});
    sbQ.push_back('{player: 2, rank: 9'h066, tmo: 1'b0});
    applyStimulus(4'b0100);
    waitStart(20);
    stepCycle();
    stepCycle();
    eval_done = 1'b1;
    eval_rank = 9'h055;
    applyStimulus(4'b0100);
    stepCycle();
    checkOutput("repend_pd", 32'(player_done), 32'b0100);
    checkOutput("repend_pend", 32'(pending), 32'b0100);
    waitStart(20);
    checkOutput("repend_cleared", 32'(pending), 32'd0);
    stepCycle();
    eval_done = 1'b1;
    eval_rank = 9'h066;
    waitIdle(20);

    // Reset in WAIT_DONE with 0110 pending
    expGrantQ.push_back(0);
    applyStimulus(4'b0001);
    waitStart(20);
    applyStimulus(4'b0110);
    stepCycle();
    checkOutput("pre_rst_pend", 32'(pending), 32'b0110);
    checkOutput("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_pend", 32'(pending), 32'd0);
    checkOutput("mid_rst_sel", 32'(eval_sel), 32'd0);
    checkOutput("mid_rst_rank", 32'(rank_out), 32'd0);
    checkOutput("mid_rst_pd", 32'({player_done, timeout_err, eval_start}), 32'd0);
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
    eval_done = 1'b1;
    eval_rank = 9'h1C0;
    stepCycle();
    checkOutput("late_done_pd", 32'(player_done), 32'd0);
    checkOutput("late_done_busy", 32'(busy), 32'd0);
    autoDelay = 2;
    autoRank  = 9'h0C3;
    expGrantQ.push_back(0);
    expGrantQ.push_back(2);
    sbQ.push_back('{player: 0, rank: 9'h0C3, tmo: 1'b0});
    sbQ.push_back('{player: 2, rank: 9'h0C3, tmo: 1'b0});
    applyStimulus(4'b0101);
    waitIdle(40);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/rank_eval_arbiter.md
Name: rank_eval_arbiter

Overview:
Shares one hand rank evaluator between NUM_PLAYERS poker player FSMs. Each player FSM raises its rank_enable pulse. The arbiter latches the request and grants the evaluator round-robin. It drives the evaluator's start and hand-select, then returns the rank and a one-hot done pulse to the granted player. It sits between the player FSMs and the single evaluator/hand-memory read port on the table side.

Parameters:
NUM_PLAYERS, 4, number of requesting player FSMs (2..8)
RANK_W, 9, hand rank width, matching the evaluator output
TIMEOUT_CYCLES, 64, maximum cycles in WAIT_DONE before forced abort (>=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NUM_PLAYERS  per-player evaluation request pulse (player rank_enable)
eval_start  out  1  one-cycle start pulse to evaluator
eval_sel  out  $clog2(NUM_PLAYERS)  index of hand memory the evaluator reads; stable from START through RESPOND
eval_done  in  1  evaluator completion pulse
eval_rank  in  RANK_W  evaluator result, valid when eval_done=1
player_done  out  NUM_PLAYERS  one-hot one-cycle completion pulse (player rank_done)
rank_out  out  RANK_W  result for the player flagged in player_done; held until next response
timeout_err  out  1  one-cycle pulse when a grant is aborted by timeout
busy  out  1  high whenever state != IDLE
pending  out  NUM_PLAYERS  latched, not-yet-granted requests

Behaviour:
- Reset (async, rst_n=0): state=IDLE; pending=0; eval_start=0; eval_sel=0; player_done=0; rank_out=0; timeout_err=0; wait counter=0; last_grant=NUM_PLAYERS-1, so player 0 has first priority.
- Request latch: on each edge, pending |= req. The bit for the player granted on that edge is cleared. A req on an already-pending bit is absorbed, with no double count. A req from the player currently in service sets a new pending bit. That includes a req in the same cycle as that player's eval_done.
- Grant: pick the first pending index scanning from (last_grant+1) mod N upward, with wrap. Pure combinational.
- FSM states:
  - IDLE: if pending!=0, go to START at the next edge. On that edge: eval_sel=grant, last_grant=grant, pending[grant] cleared, eval_start=1.
  - START: go to WAIT_DONE unconditionally. eval_start returns to 0. Wait counter clears.
  - WAIT_DONE:
    - On eval_done=1: go to RESPOND. rank_out=eval_rank and player_done[eval_sel]=1.
    - Otherwise, when the counter reaches TIMEOUT_CYCLES-1: go to RESPOND. rank_out=0, player_done[eval_sel]=1, timeout_err=1.
    - Otherwise the counter increments.
    - eval_done on the timeout cycle: done wins, timeout_err stays 0.
  - RESPOND: player_done and timeout_err drop to 0. Go to IDLE.
- Latency: req sampled at edge E gives eval_start high after edge E+1. eval_done sampled at edge D gives player_done high after edge D for exactly one cycle. Back-to-back grants are separated by at least one IDLE cycle.
- eval_done outside WAIT_DONE is ignored: no state change, no output.
- eval_start, player_done and timeout_err are registered. busy and pending are driven from registers.
- Reset mid-operation: the evaluation in flight is abandoned and pending is cleared. A late eval_done after reset is ignored in IDLE.
- Fairness: with all players continuously requesting, grants cycle 0,1,...,N-1,0.

Decomposition:
- Shared package poker_pkg holds:
  - arb_state_t enum {IDLE, START, WAIT_DONE, RESPOND}, 2-bit
  - RANK_W_DEFAULT=9
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: pending, last_grant.
  - Outputs: grant index, grant_valid.
  - Parameterised on NUM_PLAYERS.

Test Plan:
- Single request: req=4'b0100 for 1 cycle; evaluator returns eval_rank=9'h1A3 after 5 cycles. Expect eval_start one cycle after req edge, eval_sel=2, player_done=4'b0100 for 1 cycle, rank_out=9'h1A3, busy low one cycle later.
- Contention: req=4'b1011 in one cycle, evaluator done after 3 cycles each. Expect grant order 0,1,3; pending goes 1011→1010→1000→0000; each player_done pulses exactly once.
- Round-robin wrap: after servicing player 3, assert req=4'b1001. Expect grant to 0, then 3 (player 0 first because last_grant=3).
- Timeout: grant player 1, never assert eval_done. Expect player_done=4'b0010 and timeout_err=1 on the same cycle, TIMEOUT_CYCLES (64) cycles after leaving START, with rank_out=0. Then eval_done=1 in IDLE causes no output.
- Simultaneous events: player 2 re-requests in the same cycle as its eval_done. Expect player_done[2] pulse and pending[2]=1 afterwards, then a second grant to 2. Separately, eval_done on the timeout cycle gives rank_out=eval_rank with timeout_err=0.
- Reset mid-op: assert rst_n=0 during WAIT_DONE with pending=4'b0110. Expect all outputs 0 and state IDLE immediately. After release, first grant goes to player 0 when requested.
